// File: rtl/uart_ctrl_pkg.sv
// Shared constants and FSM state type for the uart register controller.
// Imported by uart_reg_ctrl.
package uart_ctrl_pkg;

    localparam logic [7:0] CMD_W       = 8'h57;
    localparam logic [7:0] CMD_R       = 8'h52;
    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_UNK     = 8'h3F;
    localparam logic [7:0] RSP_BADADDR = 8'h21;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC,
        SEND
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_reg_ctrl.sv
// Byte-protocol command sequencer on the uart FIFO side.
// Reads/writes a small register bank and queues a one-byte reply.
module uart_reg_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int NREG        = 4,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic [8*NREG-1:0] reg_flat,
    output logic              reg_we,
    output logic [7:0]        reg_waddr,
    output logic [7:0]        led,
    output logic [7:0]        err_count
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    state_t state, state_d;

    logic [NREG-1:0][7:0] regs;
    logic [7:0]    cmd, cmd_d;
    logic [7:0]    addr, addr_d;
    logic [7:0]    data, data_d;
    logic [7:0]    reply_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic          err_inc;
    logic          addr_ok;
    logic [AW-1:0] idx;

    assign addr_ok   = ({1'b0, addr} < 9'(NREG));
    assign idx       = addr[AW-1:0];
    assign reg_flat  = regs;
    assign led       = regs[0];
    assign reg_waddr = addr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state, strobes and datapath next values
    always_comb begin
        state_d = state;
        cmd_d   = cmd;
        addr_d  = addr;
        data_d  = data;
        reply_d = w_data;
        tcnt_d  = tcnt;
        err_inc = 1'b0;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        reg_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    cmd_d   = r_data;
                    tcnt_d  = '0;
                    if (r_data == CMD_W || r_data == CMD_R) begin
                        state_d = GET_ADDR;
                    end else begin
                        reply_d = RSP_UNK;
                        err_inc = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    addr_d  = r_data;
                    tcnt_d  = '0;
                    state_d = (cmd == CMD_W) ? GET_DATA : EXEC;
                end else if (tcnt == TMAX) begin
                    tcnt_d  = '0;
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            GET_DATA: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    data_d  = r_data;
                    tcnt_d  = '0;
                    state_d = EXEC;
                end else if (tcnt == TMAX) begin
                    tcnt_d  = '0;
                    err_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            EXEC: begin
                state_d = SEND;
                if (!addr_ok) begin
                    reply_d = RSP_BADADDR;
                    err_inc = 1'b1;
                end else if (cmd == CMD_W) begin
                    reg_we  = 1'b1;
                    reply_d = RSP_OK;
                end else begin
                    reply_d = regs[idx];
                end
            end
            SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // No FIFO traffic or register write while reset is held
        if (reset) begin
            rd_uart = 1'b0;
            wr_uart = 1'b0;
            reg_we  = 1'b0;
        end
    end

    // Datapath registers, register bank and error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd       <= 8'h00;
            addr      <= 8'h00;
            data      <= 8'h00;
            w_data    <= 8'h00;
            tcnt      <= '0;
            err_count <= 8'h00;
            regs      <= '0;
        end else begin
            cmd    <= cmd_d;
            addr   <= addr_d;
            data   <= data_d;
            w_data <= reply_d;
            tcnt   <= tcnt_d;
            if (err_inc) err_count <= sat_inc(err_count);
            if (reg_we)  regs[idx] <= data;
        end
    end

endmodule
